// File: rtl/dmux_src_if.sv
// rtl/dmux_src_if.sv - producer handshake and DMUX launch signals for dmux_src_ctrl
interface dmux_src_if #(
  parameter int WIDTH = 32
);
  // Producer side: valid/ready word handshake
  logic             s_valid;
  logic             s_ready;
  logic [WIDTH-1:0] s_data;
  // DMUX side: launch strobe, data and enable
  logic             tx_vld;
  logic [WIDTH-1:0] tx_data;
  logic             dmux_en;
  // Status
  logic             busy;
  logic [15:0]      sent_cnt;

  // Controller view
  modport slave (
    input  s_valid, s_data,
    output s_ready, tx_vld, tx_data, dmux_en, busy, sent_cnt
  );

  // Producer / observer view
  modport master (
    output s_valid, s_data,
    input  s_ready, tx_vld, tx_data, dmux_en, busy, sent_cnt
  );
endinterface

// File: rtl/dmux_src_ctrl.sv
// rtl/dmux_src_ctrl.sv - clk_a launch controller feeding the DMUX synchronizer
module dmux_src_ctrl #(
  parameter int WIDTH    = 32,
  parameter int HOLD_CYC = 4,
  parameter int GAP_CYC  = 4,
  parameter int IDLE_CYC = 8,
  parameter int WAKE_CYC = 2
) (
  input  logic      clk_a,
  input  logic      rst_n_a,
  dmux_src_if.slave bus
);

  // One shared phase counter, wide enough for the longest phase
  localparam int MAX_HG  = (HOLD_CYC > GAP_CYC) ? HOLD_CYC : GAP_CYC;
  localparam int MAX_IW  = (IDLE_CYC > WAKE_CYC) ? IDLE_CYC : WAKE_CYC;
  localparam int MAX_ALL = (MAX_HG > MAX_IW) ? MAX_HG : MAX_IW;
  localparam int CW      = $clog2(MAX_ALL + 1);

  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYC - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYC - 1);
  localparam logic [CW-1:0] IDLE_LAST = CW'(IDLE_CYC - 1);
  localparam logic [CW-1:0] WAKE_LAST = CW'(WAKE_CYC - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  typedef enum logic [2:0] {
    ST_OFF,
    ST_WAKE,
    ST_HOLD,
    ST_GAP,
    ST_IDLE
  } state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic             tx_vld_q;
  logic [WIDTH-1:0] tx_data_q;
  logic             en_q;
  logic [15:0]      cnt_sent;
  logic             ready;
  logic             xfer;

  // Words are only accepted while nothing is in flight
  assign ready = (state == ST_OFF) || (state == ST_IDLE);
  assign xfer  = bus.s_valid & ready;

  assign bus.s_ready  = ready;
  assign bus.busy     = (state == ST_WAKE) || (state == ST_HOLD) || (state == ST_GAP);
  assign bus.tx_vld   = tx_vld_q;
  assign bus.tx_data  = tx_data_q;
  assign bus.dmux_en  = en_q;
  assign bus.sent_cnt = cnt_sent;

  // Launch FSM: wake the DMUX, hold each word, force a low gap, gate off when idle
  always_ff @(posedge clk_a or negedge rst_n_a) begin
    if (!rst_n_a) begin
      state     <= ST_OFF;
      cnt       <= '0;
      tx_vld_q  <= 1'b0;
      tx_data_q <= '0;
      en_q      <= 1'b0;
      cnt_sent  <= '0;
    end else begin
      case (state)
        ST_OFF: begin
          if (xfer) begin
            state     <= ST_WAKE;
            cnt       <= '0;
            en_q      <= 1'b1;
            tx_data_q <= bus.s_data;
          end
        end
        ST_WAKE: begin
          if (cnt == WAKE_LAST) begin
            state    <= ST_HOLD;
            cnt      <= '0;
            tx_vld_q <= 1'b1;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        ST_HOLD: begin
          if (cnt == HOLD_LAST) begin
            state    <= ST_GAP;
            cnt      <= '0;
            tx_vld_q <= 1'b0;
            cnt_sent <= cnt_sent + 16'd1;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        ST_GAP: begin
          if (cnt == GAP_LAST) begin
            state <= ST_IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        ST_IDLE: begin
          // A word arriving in the terminal idle cycle still beats the gate-off
          if (xfer) begin
            state     <= ST_HOLD;
            cnt       <= '0;
            tx_vld_q  <= 1'b1;
            tx_data_q <= bus.s_data;
          end else if (cnt == IDLE_LAST) begin
            state <= ST_OFF;
            cnt   <= '0;
            en_q  <= 1'b0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        default: begin
          state    <= ST_OFF;
          cnt      <= '0;
          tx_vld_q <= 1'b0;
          en_q     <= 1'b0;
        end
      endcase
    end
  end

endmodule
